// File: rtl/adc_link_pkg.sv
// -----------------------------------------------------------------------------
// adc_link_pkg
// Shared definitions for the two-channel serial ADC link master: frame state
// encoding, default frame timing and the command/sample word widths.
// -----------------------------------------------------------------------------
package adc_link_pkg;

    localparam int unsigned SAMPLE_W    = 14;  // bits per channel sample
    localparam int unsigned CMD_W       = 16;  // bits per command word
    localparam int unsigned FRAME_CNT_W = 6;   // frame/gap counter width (FRAME_LEN <= 63)

    // Default frame timing. TX/RX offsets line up with the slave's two-flop
    // input synchronizer and its 31-bit output shift alignment.
    localparam int unsigned DEF_FRAME_LEN = 40;
    localparam int unsigned DEF_GAP_LEN   = 4;
    localparam int unsigned DEF_TX_START  = 1;
    localparam int unsigned DEF_RX_START  = 21;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } frame_state_e;

endpackage

// File: rtl/adc_period_timer.sv
// -----------------------------------------------------------------------------
// adc_period_timer
// Free-running periodic tick source for the ADC frame scheduler. Produces a
// pending flag that the scheduler consumes when it starts a periodic frame,
// and counts ticks that were dropped because the previous one was still
// pending.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_enable         timer runs while high; low clears count and pending
//   i_period         cycles between ticks; 0 stops the timer
//   i_take           scheduler is starting a periodic frame this cycle
//   o_pending        a tick is waiting to be serviced
//   o_overrun_cnt    saturating count of ticks lost to an unserviced pending
// -----------------------------------------------------------------------------
module adc_period_timer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [15:0] i_period,
    input  logic        i_take,
    output logic        o_pending,
    output logic [7:0]  o_overrun_cnt
);

    logic [15:0] count;
    logic        running;
    logic        tick;

    assign running = i_enable && (i_period != 16'd0);
    // '>=' rather than '==' so a period shortened mid-count still ticks
    // instead of wrapping through the full 16-bit range.
    assign tick    = running && (count >= (i_period - 16'd1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count         <= '0;
            o_pending     <= 1'b0;
            o_overrun_cnt <= '0;
        end else begin
            if (!i_enable) begin
                count <= '0;
            end else if (running) begin
                count <= tick ? 16'd0 : count + 16'd1;
            end

            // A tick that coincides with the scheduler taking the previous
            // one simply re-arms pending; it is not an overrun.
            if (!i_enable) begin
                o_pending <= 1'b0;
            end else if (tick) begin
                o_pending <= 1'b1;
            end else if (i_take) begin
                o_pending <= 1'b0;
            end

            if (tick && o_pending && !i_take && (o_overrun_cnt != 8'hFF)) begin
                o_overrun_cnt <= o_overrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/adc_frame_scheduler.sv
// -----------------------------------------------------------------------------
// adc_frame_scheduler
// Master-side controller for the two-channel serial ADC link. Runs fixed
// length chip-select frames, shifts a 16-bit command out MSB first and
// captures two 14-bit samples returned on the two data lines. Arbitrates the
// link between one-shot software requests (priority) and a periodic sampler.
//
// Ports:
//   i_clk, i_rst               clock (also the ADC clock), sync active-high reset
//   i_enable, i_period         periodic sampler enable and tick period
//   i_periodic_cmd             command word for periodic frames
//   i_sw_req, i_sw_cmd         software request (level) and its command word
//   o_sw_ack                   one-cycle pulse when the software frame starts
//   o_busy                     high while a frame or the following gap runs
//   o_sample_valid             one-cycle pulse when o_sample_0/1 update
//   o_sample_0, o_sample_1     captured samples from i_adc_data[0] / [1]
//   o_sample_sw                last completed frame was a software frame
//   o_overrun_cnt              saturating count of dropped periodic ticks
//   o_adc_cs_n, o_adc_data     registered chip select and command line
//   i_adc_data                 serial sample lines from the ADC
// -----------------------------------------------------------------------------
module adc_frame_scheduler
    import adc_link_pkg::*;
#(
    parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
    parameter int unsigned GAP_LEN   = DEF_GAP_LEN,
    parameter int unsigned TX_START  = DEF_TX_START,
    parameter int unsigned RX_START  = DEF_RX_START
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic [15:0]         i_period,
    input  logic [CMD_W-1:0]    i_periodic_cmd,
    input  logic                i_sw_req,
    input  logic [CMD_W-1:0]    i_sw_cmd,
    output logic                o_sw_ack,
    output logic                o_busy,
    output logic                o_sample_valid,
    output logic [SAMPLE_W-1:0] o_sample_0,
    output logic [SAMPLE_W-1:0] o_sample_1,
    output logic                o_sample_sw,
    output logic [7:0]          o_overrun_cnt,
    output logic                o_adc_cs_n,
    output logic                o_adc_data,
    input  logic [1:0]          i_adc_data
);

    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAME_LEN - 1);
    localparam logic [FRAME_CNT_W-1:0] GAP_LAST   = FRAME_CNT_W'(GAP_LEN - 1);
    localparam logic [FRAME_CNT_W-1:0] TX_FIRST   = FRAME_CNT_W'(TX_START);
    localparam logic [FRAME_CNT_W-1:0] TX_LAST    = FRAME_CNT_W'(TX_START + CMD_W - 1);
    localparam logic [FRAME_CNT_W-1:0] RX_FIRST   = FRAME_CNT_W'(RX_START);
    localparam logic [FRAME_CNT_W-1:0] RX_LAST    = FRAME_CNT_W'(RX_START + SAMPLE_W - 1);

    // Registered state
    frame_state_e           state;
    logic [FRAME_CNT_W-1:0] cnt;        // frame cycle in FRAME, gap cycle in GAP
    logic [CMD_W-1:0]       cmd;
    logic [SAMPLE_W-1:0]    cap_0;
    logic [SAMPLE_W-1:0]    cap_1;
    logic                   frame_sw;   // current frame came from software

    // Next-state values
    frame_state_e           state_n;
    logic [FRAME_CNT_W-1:0] cnt_n;
    logic [CMD_W-1:0]       cmd_n;
    logic [SAMPLE_W-1:0]    cap_0_n;
    logic [SAMPLE_W-1:0]    cap_1_n;
    logic                   frame_sw_n;
    logic [SAMPLE_W-1:0]    sample_0_n;
    logic [SAMPLE_W-1:0]    sample_1_n;
    logic                   sample_sw_n;
    logic                   sample_valid_n;
    logic                   sw_ack_n;
    logic                   adc_cs_n_n;
    logic                   adc_data_n;

    logic                   periodic_pending;
    logic                   periodic_take;

    adc_period_timer u_timer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_period      (i_period),
        .i_take        (periodic_take),
        .o_pending     (periodic_pending),
        .o_overrun_cnt (o_overrun_cnt)
    );

    assign o_busy = (state != ST_IDLE);

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        cmd_n          = cmd;
        cap_0_n        = cap_0;
        cap_1_n        = cap_1;
        frame_sw_n     = frame_sw;
        sample_0_n     = o_sample_0;
        sample_1_n     = o_sample_1;
        sample_sw_n    = o_sample_sw;
        sample_valid_n = 1'b0;
        sw_ack_n       = 1'b0;
        periodic_take  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (i_sw_req) begin
                    sw_ack_n   = 1'b1;
                    cmd_n      = i_sw_cmd;
                    frame_sw_n = 1'b1;
                    state_n    = ST_FRAME;
                    cnt_n      = '0;
                    cap_0_n    = '0;
                    cap_1_n    = '0;
                end else if (periodic_pending) begin
                    periodic_take = 1'b1;
                    cmd_n         = i_periodic_cmd;
                    frame_sw_n    = 1'b0;
                    state_n       = ST_FRAME;
                    cnt_n         = '0;
                    cap_0_n       = '0;
                    cap_1_n       = '0;
                end
            end

            ST_FRAME: begin
                if ((cnt >= RX_FIRST) && (cnt <= RX_LAST)) begin
                    cap_0_n = {cap_0[SAMPLE_W-2:0], i_adc_data[0]};
                    cap_1_n = {cap_1[SAMPLE_W-2:0], i_adc_data[1]};
                end
                if (cnt == FRAME_LAST) begin
                    // Publish the next-cycle captures so a capture window
                    // ending on the last frame cycle is not lost.
                    sample_0_n     = cap_0_n;
                    sample_1_n     = cap_1_n;
                    sample_sw_n    = frame_sw;
                    sample_valid_n = 1'b1;
                    state_n        = ST_GAP;
                    cnt_n          = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        // Pin outputs are registered, so they are computed for the frame
        // cycle that follows the coming edge (cnt_n), not the current one.
        adc_cs_n_n = (state_n != ST_FRAME);
        adc_data_n = 1'b0;
        if ((state_n == ST_FRAME) && (cnt_n >= TX_FIRST) && (cnt_n <= TX_LAST)) begin
            adc_data_n = cmd_n[4'(TX_LAST - cnt_n)];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            cmd            <= '0;
            cap_0          <= '0;
            cap_1          <= '0;
            frame_sw       <= 1'b0;
            o_sample_0     <= '0;
            o_sample_1     <= '0;
            o_sample_sw    <= 1'b0;
            o_sample_valid <= 1'b0;
            o_sw_ack       <= 1'b0;
            o_adc_cs_n     <= 1'b1;
            o_adc_data     <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            cmd            <= cmd_n;
            cap_0          <= cap_0_n;
            cap_1          <= cap_1_n;
            frame_sw       <= frame_sw_n;
            o_sample_0     <= sample_0_n;
            o_sample_1     <= sample_1_n;
            o_sample_sw    <= sample_sw_n;
            o_sample_valid <= sample_valid_n;
            o_sw_ack       <= sw_ack_n;
            o_adc_cs_n     <= adc_cs_n_n;
            o_adc_data     <= adc_data_n;
        end
    end

endmodule

// File: doc/adc_frame_scheduler.md
# adc_frame_scheduler

Master-side controller for the two-channel serial ADC link. It owns the chip-select and command line, runs fixed-length transfer frames, and captures the two 14-bit channel samples returned on the two data lines. It shares the link between a free-running periodic sampler and one-shot software requests, with software priority and overrun accounting. It sits between the register/control logic and the ADC pins, in the same `i_clk` domain that clocks the ADC chip.

## Interface
- `FRAME_LEN`, 40: cycles `o_adc_cs_n` is held low per frame (max 63).
- `GAP_LEN`, 4: minimum cycles `o_adc_cs_n` is high between frames (min 3).
- `TX_START`, 1: frame cycle on which command bit 15 is driven.
- `RX_START`, 21: frame cycle on which sample bit 13 is captured.
- `i_clk`  in  1  system clock, also the ADC clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  periodic sampling enable.
- `i_period`  in  16  cycles between periodic ticks; 0 means no ticks.
- `i_periodic_cmd`  in  16  command word sent on periodic frames.
- `i_sw_req`  in  1  software frame request, level, held until ack.
- `i_sw_cmd`  in  16  command word for the software frame.
- `o_sw_ack`  out  1  one-cycle pulse; software request accepted.
- `o_busy`  out  1  high in FRAME and GAP.
- `o_sample_valid`  out  1  one-cycle pulse; samples updated.
- `o_sample_0`  out  14  channel 0 sample from `i_adc_data[0]`.
- `o_sample_1`  out  14  channel 1 sample from `i_adc_data[1]`.
- `o_sample_sw`  out  1  1 if the last completed frame was a software frame.
- `o_overrun_cnt`  out  8  saturating count of dropped periodic ticks.
- `o_adc_cs_n`  out  1  chip select, active low, registered.
- `o_adc_data`  out  1  command serial out, MSB first, registered.
- `i_adc_data`  in  2  serial sample lines, MSB first.

## Operation
- Reset values:
  - `o_adc_cs_n` = 1.
  - All other outputs 0.
  - State IDLE; timer, pending flag and shift registers cleared.
- Periodic timer:
  - Counts while `i_enable`=1 and `i_period`≠0.
  - Ticks when the count reaches `i_period`-1, then reloads to 0.
  - Deasserting `i_enable` clears the count and the pending flag.
- Each tick sets `periodic_pending`. A tick arriving while `periodic_pending` is already set increments `o_overrun_cnt`; the counter saturates at 255.
- States:
  - IDLE: start a frame if `i_sw_req` or `periodic_pending`; software wins.
    - Software start: pulse `o_sw_ack`, latch `i_sw_cmd`.
    - Periodic start: clear `periodic_pending`, latch `i_periodic_cmd`.
    - Either start goes to FRAME with the frame counter at 0.
  - FRAME:
    - `o_adc_cs_n`=0.
    - Counter increments each cycle.
    - On `TX_START`..`TX_START`+15, `o_adc_data` drives command bits 15..0; otherwise 0.
    - On `RX_START`..`RX_START`+13, shift `i_adc_data[1:0]` into two 14-bit registers.
    - At counter = `FRAME_LEN`-1: transfer the captures to `o_sample_0/1`, set `o_sample_sw`, pulse `o_sample_valid`, go to GAP.
  - GAP: `o_adc_cs_n`=1 for `GAP_LEN` cycles, then IDLE.
- A tick during FRAME/GAP only sets pending; it never aborts a frame.
- `i_sw_req` arriving mid-frame waits. If software and periodic are both pending at IDLE, software goes first and periodic runs next.
- Reset mid-frame: the next edge drives `o_adc_cs_n`=1 and discards partial captures, with no `o_sample_valid`.

## Timing
- Frame start: `o_sw_ack` and the IDLE→FRAME transition occur on the same edge; `o_adc_cs_n` goes low on that edge.
- Frame-cycle n is the n-th cycle after `o_adc_cs_n` falls (falling cycle = 0).
- Sample latency: `o_sample_valid` rises `FRAME_LEN` cycles after `o_adc_cs_n` falls, coinciding with `o_adc_cs_n` rising.
- Minimum frame-to-frame spacing: `FRAME_LEN`+`GAP_LEN`+1 cycles (45 at defaults).
- Default `TX_START`/`RX_START` match the slave's two-flop input synchronizer and 31-bit output shift alignment.

## Structure
- Shared package `adc_link_pkg`:
  - State enum.
  - Default `FRAME_LEN`, `GAP_LEN`, `TX_START`, `RX_START`.
  - Sample width 14 and command width 16.
- One natural sub-module: `adc_period_timer` (counter, tick, pending flag, overrun counter).
- The frame FSM and shifters stay in the top level.

## Test plan
- Bench ties pins to the behavioural ADC slave model. Software request with `i_sw_cmd`=16'hA5C3, slave values 14'h1ABC/14'h0123 -> `o_sample_0`=14'h1ABC, `o_sample_1`=14'h0123, `o_sample_sw`=1, slave write value 16'hA5C3.
- `i_enable`=1, `i_period`=100, 3 ticks -> 3 `o_sample_valid` pulses 100 cycles apart, each 40 cycles after `o_adc_cs_n` falls, `o_overrun_cnt`=0.
- `i_period`=20 -> frames back-to-back at 45-cycle spacing, `o_overrun_cnt` increments, saturates at 255.
- `i_sw_req` and periodic tick in the same IDLE cycle -> software frame first, periodic frame starts exactly 45 cycles later.
- `i_rst` at frame-cycle 25 -> `o_adc_cs_n`=1 next cycle, no `o_sample_valid`, samples read 0.
- `i_period`=0 with `i_enable`=1 -> no frames, `o_busy` stays 0.
